// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration interface: request lines from the control unit in,
// one-hot grant plus mux select and status back out.
interface bus_source_arbiter_if #(
    parameter int N_REQ = 24,
    parameter int SEL_W = 5
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             bus_busy;
    logic [3:0]       hold_count;

    // Arbiter side: samples requests, drives grant/select/status.
    modport master (
        input  req,
        output grant,
        output sel,
        output bus_busy,
        output hold_count
    );

    // Requester side: raises requests, observes grant/select/status.
    modport slave (
        output req,
        input  grant,
        input  sel,
        input  bus_busy,
        input  hold_count
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter choosing which of the 24 bus sources drives the shared
// 32-bit datapath bus. Grant and mux select are registered together so they
// never skew; a waiting source forces rotation after MAX_HOLD owned cycles.
module bus_source_arbiter #(
    parameter int N_REQ    = 24,
    parameter int SEL_W    = 5,
    parameter int MAX_HOLD = 8,
    parameter int IDLE_SEL = 31
) (
    input  logic                 clk,
    input  logic                 clr,
    bus_source_arbiter_if.master bus
);
    localparam logic [SEL_W-1:0] IDLE_SEL_C = SEL_W'(IDLE_SEL);
    localparam logic [SEL_W-1:0] LAST_IDX_C = SEL_W'(N_REQ - 1);
    localparam logic [SEL_W:0]   N_REQ_W_C  = (SEL_W + 1)'(N_REQ);
    localparam logic [3:0]       MAX_HOLD_C = 4'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // First set bit of vec searching upward from start with wrap; returns {found, index}.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] vec,
                                               input logic [SEL_W-1:0] start);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W:0]   pos;
        found = 1'b0;
        idx   = IDLE_SEL_C;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, start} + (SEL_W + 1)'(i);
            pos = (pos >= N_REQ_W_C) ? (pos - N_REQ_W_C) : pos;
            if (!found && vec[pos[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[SEL_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t           state_r, state_s;
    logic [SEL_W-1:0] ptr_r, ptr_s;
    logic [N_REQ-1:0] grant_r, grant_s;
    logic [SEL_W-1:0] sel_r, sel_s;
    logic             busy_r, busy_s;
    logic [3:0]       hold_r, hold_s;

    logic             own_req_s;
    logic             others_s;
    logic [SEL_W-1:0] next_ptr_s;
    logic [SEL_W:0]   pick_idle_s;
    logic [SEL_W:0]   pick_next_s;

    // Owner-relative request terms and the two candidate round-robin picks.
    always_comb begin
        own_req_s = |(bus.req & grant_r);
        others_s  = |(bus.req & ~grant_r);
        if (sel_r >= LAST_IDX_C) begin
            next_ptr_s = {SEL_W{1'b0}};
        end else begin
            next_ptr_s = sel_r + {{(SEL_W-1){1'b0}}, 1'b1};
        end
        // While idle grant_r is zero so the mask is a no-op; while owning, the
        // mask keeps the current owner out of the pass that replaces it.
        pick_idle_s = rr_pick(bus.req, ptr_r);
        pick_next_s = rr_pick(bus.req & ~grant_r, next_ptr_s);
    end

    // Next-state and next-output decision for the IDLE/OWN ownership FSM.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        grant_s = grant_r;
        sel_s   = sel_r;
        busy_s  = busy_r;
        hold_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_idle_s[SEL_W]) begin
                    grant_s = to_onehot(pick_idle_s[SEL_W-1:0]);
                    sel_s   = pick_idle_s[SEL_W-1:0];
                    busy_s  = 1'b1;
                    hold_s  = 4'd1;
                    state_s = ST_OWN;
                end else begin
                    grant_s = {N_REQ{1'b0}};
                    sel_s   = IDLE_SEL_C;
                    busy_s  = 1'b0;
                    hold_s  = 4'd0;
                    state_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                // Hand over on voluntary release, or when someone is waiting
                // and the owner has used up its burst allowance.
                if (!own_req_s || (others_s && (hold_r >= MAX_HOLD_C))) begin
                    ptr_s = next_ptr_s;
                    if (pick_next_s[SEL_W]) begin
                        grant_s = to_onehot(pick_next_s[SEL_W-1:0]);
                        sel_s   = pick_next_s[SEL_W-1:0];
                        busy_s  = 1'b1;
                        hold_s  = 4'd1;
                        state_s = ST_OWN;
                    end else begin
                        grant_s = {N_REQ{1'b0}};
                        sel_s   = IDLE_SEL_C;
                        busy_s  = 1'b0;
                        hold_s  = 4'd0;
                        state_s = ST_IDLE;
                    end
                end else if (hold_r < MAX_HOLD_C) begin
                    hold_s = hold_r + 4'd1;
                end else begin
                    hold_s = hold_r;
                end
            end
            default: begin
                grant_s = {N_REQ{1'b0}};
                sel_s   = IDLE_SEL_C;
                busy_s  = 1'b0;
                hold_s  = 4'd0;
                ptr_s   = {SEL_W{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs; clr forces idle immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
            ptr_r   <= {SEL_W{1'b0}};
            grant_r <= {N_REQ{1'b0}};
            sel_r   <= IDLE_SEL_C;
            busy_r  <= 1'b0;
            hold_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            grant_r <= grant_s;
            sel_r   <= sel_s;
            busy_r  <= busy_s;
            hold_r  <= hold_s;
        end
    end

    assign bus.grant      = grant_r;
    assign bus.sel        = sel_r;
    assign bus.bus_busy   = busy_r;
    assign bus.hold_count = hold_r;
endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Round-robin arbiter for the 32-bit shared datapath bus. Decides which of the 24 bus sources drives the bus each cycle.
- Sources are R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort and C.
- Drives the 5-bit select of the 24:1 bus multiplexer and returns a one-hot grant to the requesting units.
- Sits between the control unit's source-request lines and the bus mux. Enforces single-driver ownership, bounded burst hold and an all-zero bus when idle.

Parameters:
- N_REQ, 24, number of bus sources; request index i maps to bus mux input i.
- SEL_W, 5, width of the bus mux select.
- MAX_HOLD, 8, maximum consecutive cycles one source may own the bus while another source is waiting.
- IDLE_SEL, 31, select code driven when no source is granted; mux returns 32'h00000000 for codes 24–31.

Ports:
- clk, input, 1, rising-edge clock.
- clr, input, 1, asynchronous active-high reset.
- req, input, N_REQ, per-source bus request; level-sensitive, held high while source wants the bus.
- grant, output, N_REQ, one-hot registered grant; at most one bit set.
- sel, output, SEL_W, registered binary encode of grant; IDLE_SEL when grant is zero.
- bus_busy, output, 1, high when any grant bit is set.
- hold_count, output, 4, cycles the current owner has held the bus, saturating at MAX_HOLD.

Behaviour:
- Reset (clr high, asynchronous):
  - grant=0, sel=IDLE_SEL, bus_busy=0, hold_count=0.
  - Round-robin pointer ptr=0, meaning the search starts at index 0. State=IDLE.
  - Effect is immediate, mid-grant included. First grant after clr falls occurs at the earliest next rising edge.
- States: IDLE, OWN.
- IDLE:
  - If req≠0, select the first set req bit searching upward from ptr with wrap at N_REQ-1→0.
  - Next edge: grant=that one-hot, sel=its index, bus_busy=1, hold_count=1, go to OWN.
  - If req=0, stay in IDLE with outputs at idle values.
- OWN, owner k:
  - req[k] low: release at next edge, ptr=(k+1) mod N_REQ.
    - If another req is set, grant it on that same edge (no idle gap) and stay in OWN with hold_count=1.
    - Otherwise go to IDLE with idle outputs.
  - req[k] high, no other req set: keep grant; hold_count increments, saturating at MAX_HOLD.
  - req[k] high, another req set, hold_count<MAX_HOLD: keep grant, increment hold_count.
  - req[k] high, another req set, hold_count=MAX_HOLD: forced rotation at next edge.
    - ptr=(k+1) mod N_REQ; grant the next requester found from the new ptr, which excludes k on this pass.
    - hold_count=1.
- Latency: request to grant is 1 cycle. Release to next grant is 1 cycle.
- sel always equals the binary index of grant, or IDLE_SEL; both are updated on the same edge, never skewed.
- A req bit at index ≥ N_REQ does not exist. sel never takes values 24–30 while bus_busy=1.
- Simultaneous requests are resolved purely by ptr order. There is no fixed priority.
- Requests changing in the same cycle as a grant edge are sampled on that edge only; no combinational path from req to grant or sel.
- hold_count is 4 bits. MAX_HOLD must be ≤15.

Test Plan:
- Reset/idle:
  - Stimulus: assert clr mid-grant with req=24'h000010.
  - Required: grant=0, sel=31 and bus_busy=0 immediately without a clock edge.
  - After release: sel=4 and grant=24'h000010 one edge later.
- Round-robin:
  - Stimulus: ptr=0, req=24'h000005 held as 1-cycle bursts, each owner dropping req after its grant.
  - Required: grants alternate source 0 → 2 → 0 → 2; sel = 0, 2, 0, 2; no idle cycle between them.
- Forced rotation:
  - Stimulus: source 20 (PC) holds req continuously; source 3 raises req on cycle 2.
  - Required: source 20 owns for exactly 8 cycles, hold_count reaches 8, then grant moves to source 3 with sel=3 and hold_count=1.
- Uncontended burst:
  - Stimulus: source 21 (MDR) alone holds req for 20 cycles.
  - Required: grant never drops; hold_count saturates at 8.
  - On release: next edge gives sel=31 and bus_busy=0.
- Wrap-around:
  - Stimulus: owner 23 releases while req bits 1 and 22 are set.
  - Required: ptr wraps to 0 and grant goes to 1, not 22.
- One-hot/sel invariant:
  - Stimulus: 10k cycles of random req.
  - Required (assertion checks every cycle): grant is zero or one-hot; sel=index(grant) when busy, else 31; grant bit set only if that req was high on the prior edge.
